osd_font_loader: RTL and testbench

//  Writer side of the OSD font/overlay RAMs. Receives a byte stream (UART/host bridge),

---
 rtl/osd_pkg.sv | 25 ++
 rtl/osd_pix_counter.sv | 66 ++++++
 rtl/osd_font_loader.sv | 205 ++++++++++++++++++++
 tb/tb_osd_font_loader.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/osd_pkg.sv
// Shared OSD definitions: stream framing bytes, colour layer codes, loader
// state encoding and default glyph geometry. The overlay reader and the colour
// FSM use the same values.
package osd_pkg;

    localparam logic [7:0] SYNC0 = 8'hA5;
    localparam logic [7:0] SYNC1 = 8'h5A;

    localparam logic [1:0] LAYER_RED   = 2'd0;
    localparam logic [1:0] LAYER_GREEN = 2'd1;
    localparam logic [1:0] LAYER_BLUE  = 2'd2;
    localparam logic [1:0] LAYER_BLACK = 2'd3;

    localparam int OSD_W  = 50;
    localparam int OSD_H  = 50;
    localparam int OSD_AW = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC2 = 2'd1,
        ST_LAYER = 2'd2,
        ST_PIXEL = 2'd3
    } osd_ld_state_e;

endpackage

// File: rtl/osd_pix_counter.sv
// Glyph pixel walker: tracks column x and the address of the current row's
// first pixel, and produces the RAM address for the current pixel plus a flag
// marking the final pixel of the glyph. Rows advance by adding W, so there is
// no multiplier anywhere in the address path.
module osd_pix_counter #(
    parameter int W      = 50,
    parameter int H      = 50,
    parameter int AW     = 12,
    parameter int MIRROR = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          step,
    output logic [AW-1:0] addr,
    output logic          last
);

    localparam int XW = (W > 1) ? $clog2(W) : 1;
    localparam logic [XW-1:0] X_LAST   = XW'(W - 1);
    localparam logic [AW-1:0] ROW_STEP = AW'(W);
    localparam logic [AW-1:0] ROW_END  = AW'(W - 1);
    localparam logic [AW-1:0] ROW_LAST = AW'((H - 1) * W);

    logic [XW-1:0] x_q, x_d;
    logic [AW-1:0] row_base_q, row_base_d;

    // Next column / row base: clear wins, otherwise wrap x at the row end.
    always_comb begin
        x_d        = x_q;
        row_base_d = row_base_q;
        if (clear) begin
            x_d        = '0;
            row_base_d = '0;
        end else if (step) begin
            if (x_q == X_LAST) begin
                x_d        = '0;
                row_base_d = row_base_q + ROW_STEP;
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q        <= '0;
            row_base_q <= '0;
        end else begin
            x_q        <= x_d;
            row_base_q <= row_base_d;
        end
    end

    // Mirrored glyphs walk each row from its high end down to the row base.
    always_comb begin
        if (MIRROR != 0) begin
            addr = row_base_q + ROW_END - AW'(x_q);
        end else begin
            addr = row_base_q + AW'(x_q);
        end
        last = (x_q == X_LAST) && (row_base_q == ROW_LAST);
    end

endmodule

// File: rtl/osd_font_loader.sv
// Writer side of the OSD layer RAMs: frames the host byte stream with a
// two-byte sync, picks the target colour layer, packs R/G/B bytes into 24-bit
// pixels and writes one W x H glyph. A stalled host aborts the frame after
// TIMEOUT idle cycles; whatever was already written stays in the RAM.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | hunting for the first sync byte
//  ST_SYNC2 | first sync seen, expecting the second (repeat first = stay)
//  ST_LAYER | next byte selects the layer; upper six bits must be zero
//  ST_PIXEL | collecting R,G,B triplets; every B byte writes one pixel
module osd_font_loader
    import osd_pkg::*;
#(
    parameter int W       = OSD_W,
    parameter int H       = OSD_H,
    parameter int AW      = OSD_AW,
    parameter int MIRROR  = 0,
    parameter int TIMEOUT = 65535
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic          wr_en,
    output logic [1:0]    wr_layer,
    output logic [AW-1:0] wr_addr,
    output logic [23:0]   wr_data,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

    osd_ld_state_e state_q, state_d;
    logic [7:0]    r_q, r_d, g_q, g_d;
    logic [1:0]    bcnt_q, bcnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          wr_en_q, wr_en_d;
    logic [1:0]    wr_layer_q, wr_layer_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [23:0]   wr_data_q, wr_data_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          s_ready_q;

    logic          accept;
    logic          in_frame;
    logic          tmo_fire;
    logic          pix_clear;
    logic          pix_step;
    logic [AW-1:0] pix_addr;
    logic          pix_last;

    assign accept   = s_valid & s_ready_q;
    assign in_frame = (state_q == ST_LAYER) || (state_q == ST_PIXEL);

    osd_pix_counter #(
        .W      (W),
        .H      (H),
        .AW     (AW),
        .MIRROR (MIRROR)
    ) u_pix_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (pix_clear),
        .step  (pix_step),
        .addr  (pix_addr),
        .last  (pix_last)
    );

    // Idle watchdog: reloads on every accepted byte, counts down only inside a frame.
    always_comb begin
        tmo_d    = tmo_q;
        tmo_fire = 1'b0;
        if (accept) begin
            tmo_d = TMO_LOAD;
        end else if (in_frame) begin
            if (tmo_q == '0) begin
                tmo_fire = 1'b1;
            end else begin
                tmo_d = tmo_q - TW'(1);
            end
        end
    end

    // Next state, pixel packing and registered output values.
    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        g_d        = g_q;
        bcnt_d     = bcnt_q;
        wr_en_d    = 1'b0;
        wr_layer_d = wr_layer_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        pix_clear  = 1'b0;
        pix_step   = 1'b0;

        if (tmo_fire) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
        end else if (accept) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (s_data == SYNC0) state_d = ST_SYNC2;
                end
                ST_SYNC2: begin
                    if (s_data == SYNC1) begin
                        state_d = ST_LAYER;
                    end else if (s_data != SYNC0) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LAYER: begin
                    if (s_data[7:2] == 6'd0) begin
                        wr_layer_d = s_data[1:0];
                        pix_clear  = 1'b1;
                        bcnt_d     = 2'd0;
                        state_d    = ST_PIXEL;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_PIXEL: begin
                    case (bcnt_q)
                        2'd0: begin
                            r_d    = s_data;
                            bcnt_d = 2'd1;
                        end
                        2'd1: begin
                            g_d    = s_data;
                            bcnt_d = 2'd2;
                        end
                        default: begin
                            wr_en_d   = 1'b1;
                            wr_data_d = {r_q, g_q, s_data};
                            wr_addr_d = pix_addr;
                            pix_step  = 1'b1;
                            bcnt_d    = 2'd0;
                            if (pix_last) begin
                                done_d  = 1'b1;
                                state_d = ST_IDLE;
                            end
                        end
                    endcase
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Keep busy through the done/err cycle so it drops on the cycle after.
        busy_d = (state_d == ST_PIXEL) || ((done_d || err_d) && busy_q);
    end

    // State, packing and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            r_q        <= '0;
            g_q        <= '0;
            bcnt_q     <= '0;
            tmo_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_layer_q <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            s_ready_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            g_q        <= g_d;
            bcnt_q     <= bcnt_d;
            tmo_q      <= tmo_d;
            wr_en_q    <= wr_en_d;
            wr_layer_q <= wr_layer_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            s_ready_q  <= 1'b1;
        end
    end

    assign s_ready  = s_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_layer = wr_layer_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_osd_font_loader.sv
// Bench for osd_font_loader: two instances (normal and mirrored addressing)
// fed with randomized byte streams; a reference model derives every expected
// RAM write from the glyph geometry and compares it with the observed writes.
module tb_osd_font_loader;

    localparam int W    = 50;
    localparam int H    = 50;
    localparam int AW   = 12;
    localparam int NPIX = W * H;
    localparam int TMO  = 100;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    sa_data, sb_data;
    logic          sa_valid, sb_valid;
    logic          a_s_ready, a_wr_en, a_busy, a_done, a_err;
    logic [1:0]    a_wr_layer;
    logic [AW-1:0] a_wr_addr;
    logic [23:0]   a_wr_data;
    logic          b_s_ready, b_wr_en, b_busy, b_done, b_err;
    logic [1:0]    b_wr_layer;
    logic [AW-1:0] b_wr_addr;
    logic [23:0]   b_wr_data;

    osd_font_loader #(.W(W), .H(H), .AW(AW), .MIRROR(0), .TIMEOUT(TMO)) dut_a (
        .clk(clk), .rst_n(rst_n), .s_data(sa_data), .s_valid(sa_valid), .s_ready(a_s_ready),
        .wr_en(a_wr_en), .wr_layer(a_wr_layer), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .busy(a_busy), .done(a_done), .err(a_err));

    osd_font_loader #(.W(W), .H(H), .AW(AW), .MIRROR(1), .TIMEOUT(TMO)) dut_b (
        .clk(clk), .rst_n(rst_n), .s_data(sb_data), .s_valid(sb_valid), .s_ready(b_s_ready),
        .wr_en(b_wr_en), .wr_layer(b_wr_layer), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .busy(b_busy), .done(b_done), .err(b_err));

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [23:0]   data;
        logic [1:0]    layer;
        logic          done;
        int            cyc;
    } wr_t;

    typedef struct {
        int          addr;
        logic [23:0] data;
        int          cyc;
    } exp_t;

    wr_t  mon_a[$], mon_b[$];
    exp_t exp_a[$], exp_b[$];
    int   cyc = 0;
    int   acc_cyc;
    int   err_a, err_cyc_a, done_a, clash_a, late_a;
    int   err_b, done_b, clash_b, late_b;
    bit   a_prev_end, b_prev_end;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   shown = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Write/pulse logger for both instances, sampled mid-cycle.
    initial forever begin
        wr_t w;
        @(negedge clk);
        if (!rst_n) begin
            a_prev_end = 1'b0;
            b_prev_end = 1'b0;
        end else begin
            if (a_wr_en) begin
                w.addr = a_wr_addr; w.data = a_wr_data; w.layer = a_wr_layer;
                w.done = a_done; w.cyc = cyc;
                mon_a.push_back(w);
            end
            if (b_wr_en) begin
                w.addr = b_wr_addr; w.data = b_wr_data; w.layer = b_wr_layer;
                w.done = b_done; w.cyc = cyc;
                mon_b.push_back(w);
            end
            if (a_err) begin err_a++; err_cyc_a = cyc; end
            if (b_err) err_b++;
            if (a_done) done_a++;
            if (b_done) done_b++;
            if ((a_err && a_done) || (a_done && !a_wr_en)) clash_a++;
            if ((b_err && b_done) || (b_done && !b_wr_en)) clash_b++;
            if (a_prev_end && a_busy) late_a++;
            if (b_prev_end && b_busy) late_b++;
            a_prev_end = a_done | a_err;
            b_prev_end = b_done | b_err;
        end
    end

    // Reference address: pixel n sits at column n%W of row n/W.
    function automatic int exp_addr(input int n, input bit mir);
        int y = n / W;
        int x = n % W;
        return mir ? ((y + 1) * W - 1 - x) : (y * W + x);
    endfunction

    function automatic int rand_gap();
        return ($urandom_range(0, 7) == 0) ? 1 : 0;
    endfunction

    function automatic logic [7:0] rnd_pix_byte();
        int k = $urandom_range(0, 7);
        if (k == 0) return 8'hA5;
        if (k == 1) return 8'h5A;
        return 8'($urandom);
    endfunction

    function automatic logic [7:0] rnd_non_sync();
        logic [7:0] v = 8'($urandom);
        if (v == 8'hA5) v = 8'h00;
        return v;
    endfunction

    task automatic send_byte(input int d, input logic [7:0] b, input int gap);
        if (d == 0) begin sa_data = b; sa_valid = 1'b1; end
        else begin sb_data = b; sb_valid = 1'b1; end
        @(posedge clk); #1;
        acc_cyc  = cyc;
        sa_valid = 1'b0;
        sb_valid = 1'b0;
        sa_data  = 8'($urandom);
        sb_data  = 8'($urandom);
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_hdr(input int d, input logic [7:0] layer);
        send_byte(d, 8'hA5, rand_gap());
        send_byte(d, 8'h5A, rand_gap());
        send_byte(d, layer, 0);
    endtask

    task automatic send_pixels(input int d, input int first, input int count, input bit patterned);
        for (int n = first; n < first + count; n++) begin
            logic [7:0] r, g, b;
            exp_t e;
            if (patterned) begin
                r = 8'(n); g = ~8'(n); b = 8'h3C;
            end else begin
                r = rnd_pix_byte(); g = rnd_pix_byte(); b = rnd_pix_byte();
            end
            send_byte(d, r, rand_gap());
            send_byte(d, g, rand_gap());
            send_byte(d, b, 0);
            e.addr = exp_addr(n, d == 1);
            e.data = {r, g, b};
            e.cyc  = acc_cyc;
            if (d == 0) exp_a.push_back(e); else exp_b.push_back(e);
            idle_cycles(rand_gap());
        end
    endtask

    task automatic clear_logs();
        mon_a.delete(); mon_b.delete(); exp_a.delete(); exp_b.delete();
        err_a = 0; err_cyc_a = -1; done_a = 0; clash_a = 0; late_a = 0;
        err_b = 0; done_b = 0; clash_b = 0; late_b = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sa_valid = 1'b0; sb_valid = 1'b0; sa_data = 8'h00; sb_data = 8'h00;
        clear_logs();
        repeat (3) @(posedge clk); #1;
        n_cmp++;
        if ({a_s_ready, a_wr_en, a_busy, a_done, a_err, a_wr_layer, a_wr_addr, a_wr_data} !== '0 ||
            {b_s_ready, b_wr_en, b_busy, b_done, b_err, b_wr_layer, b_wr_addr, b_wr_data} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got a_ready=%b a_wr=%b a_busy=%b a_addr=%0d a_data=%h b_ready=%b, want all zero",
                     a_s_ready, a_wr_en, a_busy, a_wr_addr, a_wr_data, b_s_ready);
        end
        rst_n = 1'b1;
        n_cmp++;
        if (a_s_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL ready_before_clk got %b want 0", a_s_ready);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (a_s_ready !== 1'b1 || b_s_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_after_clk got a=%b b=%b want 1", a_s_ready, b_s_ready);
        end
    endtask

    task automatic test_full_frame();
        clear_logs();
        send_byte(0, 8'hA5, 0);
        send_byte(0, 8'h5A, 0);
        n_cmp++;
        if (a_busy !== 1'b0) begin n_bad++; $display("FAIL busy_before_layer got %b want 0", a_busy); end
        send_byte(0, 8'h02, 0);
        n_cmp++;
        if (a_busy !== 1'b1) begin n_bad++; $display("FAIL busy_after_layer got %b want 1", a_busy); end
        send_pixels(0, 0, NPIX, 1'b1);
        idle_cycles(3);
        n_cmp++;
        if (mon_a.size() != NPIX) begin n_bad++; $display("FAIL t1_count got %0d want %0d", mon_a.size(), NPIX); end
        for (int i = 0; i < mon_a.size() && i < exp_a.size(); i++) begin
            n_cmp++;
            if (mon_a[i].addr !== AW'(exp_a[i].addr) || mon_a[i].data !== exp_a[i].data || mon_a[i].layer !== 2'd2 ||
                mon_a[i].cyc != exp_a[i].cyc || mon_a[i].done !== (i == NPIX - 1)) begin
                n_bad++;
                if (shown++ < 20)
                    $display("FAIL t1_write[%0d] got addr=%0d data=%h layer=%0d cyc=%0d done=%b want addr=%0d data=%h layer=2 cyc=%0d done=%b",
                             i, mon_a[i].addr, mon_a[i].data, mon_a[i].layer, mon_a[i].cyc, mon_a[i].done,
                             exp_a[i].addr, exp_a[i].data, exp_a[i].cyc, i == NPIX - 1);
            end
        end
        n_cmp++;
        if (done_a != 1 || err_a != 0 || clash_a != 0 || late_a != 0 || a_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL t1_end got done=%0d err=%0d clash=%0d late_busy=%0d busy=%b want 1 0 0 0 0",
                     done_a, err_a, clash_a, late_a, a_busy);
        end
    endtask

    task automatic test_mirror();
        clear_logs();
        send_hdr(1, 8'h00);
        send_pixels(1, 0, NPIX, 1'b0);
        idle_cycles(3);
        n_cmp++;
        if (mon_b.size() != NPIX) begin n_bad++; $display("FAIL t2_count got %0d want %0d", mon_b.size(), NPIX); end
        for (int i = 0; i < mon_b.size() && i < exp_b.size(); i++) begin
            n_cmp++;
            if (mon_b[i].addr !== AW'(exp_b[i].addr) || mon_b[i].data !== exp_b[i].data || mon_b[i].layer !== 2'd0 ||
                mon_b[i].cyc != exp_b[i].cyc || mon_b[i].done !== (i == NPIX - 1)) begin
                n_bad++;
                if (shown++ < 20)
                    $display("FAIL t2_write[%0d] got addr=%0d data=%h layer=%0d cyc=%0d done=%b want addr=%0d data=%h layer=0 cyc=%0d",
                             i, mon_b[i].addr, mon_b[i].data, mon_b[i].layer, mon_b[i].cyc, mon_b[i].done,
                             exp_b[i].addr, exp_b[i].data, exp_b[i].cyc);
            end
        end
        if (mon_b.size() == NPIX) begin
            n_cmp++;
            if (mon_b[0].addr !== AW'(49) || mon_b[49].addr !== AW'(0) || mon_b[50].addr !== AW'(99) ||
                mon_b[NPIX - 1].addr !== AW'(2450)) begin
                n_bad++;
                $display("FAIL t2_corners got %0d %0d %0d %0d want 49 0 99 2450",
                         mon_b[0].addr, mon_b[49].addr, mon_b[50].addr, mon_b[NPIX - 1].addr);
            end
        end
        n_cmp++;
        if (done_b != 1 || err_b != 0 || clash_b != 0 || late_b != 0 || b_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL t2_end got done=%0d err=%0d clash=%0d late_busy=%0d busy=%b want 1 0 0 0 0",
                     done_b, err_b, clash_b, late_b, b_busy);
        end
    endtask

    task automatic test_bad_layer();
        int lay_cyc;
        clear_logs();
        send_byte(0, 8'hA5, 0);
        send_byte(0, 8'h5A, 0);
        send_byte(0, 8'h07, 0);
        lay_cyc = acc_cyc;
        idle_cycles(4);
        n_cmp++;
        if (err_a != 1 || err_cyc_a != lay_cyc || mon_a.size() != 0 || a_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL t3_bad_layer got err_cycles=%0d err_at=%0d writes=%0d busy=%b want 1 %0d 0 0",
                     err_a, err_cyc_a, mon_a.size(), a_busy, lay_cyc);
        end
        send_hdr(0, 8'h03);
        send_pixels(0, 0, NPIX, 1'b0);
        idle_cycles(3);
        n_cmp++;
        if (mon_a.size() != NPIX) begin n_bad++; $display("FAIL t3_count got %0d want %0d", mon_a.size(), NPIX); end
        for (int i = 0; i < mon_a.size() && i < exp_a.size(); i++) begin
            n_cmp++;
            if (mon_a[i].addr !== AW'(exp_a[i].addr) || mon_a[i].data !== exp_a[i].data || mon_a[i].layer !== 2'd3 ||
                mon_a[i].done !== (i == NPIX - 1)) begin
                n_bad++;
                if (shown++ < 20)
                    $display("FAIL t3_write[%0d] got addr=%0d data=%h layer=%0d want addr=%0d data=%h layer=3",
                             i, mon_a[i].addr, mon_a[i].data, mon_a[i].layer, exp_a[i].addr, exp_a[i].data);
            end
        end
        n_cmp++;
        if (done_a != 1 || err_a != 1 || clash_a != 0) begin
            n_bad++;
            $display("FAIL t3_end got done=%0d err=%0d clash=%0d want 1 1 0", done_a, err_a, clash_a);
        end
    endtask

    task automatic test_sync_hunt();
        logic [7:0] junk [10];
        junk = '{8'h5A, 8'hA5, 8'h33, 8'h5A, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        clear_logs();
        foreach (junk[k]) send_byte(0, junk[k], rand_gap());
        idle_cycles(3);
        n_cmp++;
        if (mon_a.size() != 0 || a_busy !== 1'b0 || done_a != 0) begin
            n_bad++;
            $display("FAIL t4_no_start got writes=%0d busy=%b done=%0d want 0 0 0", mon_a.size(), a_busy, done_a);
        end
        send_byte(0, 8'hA5, 0);
        send_byte(0, 8'hA5, 0);
        send_byte(0, 8'h5A, 0);
        send_byte(0, 8'h01, 0);
        n_cmp++;
        if (a_busy !== 1'b1) begin n_bad++; $display("FAIL t4_busy got %b want 1", a_busy); end
        send_pixels(0, 0, NPIX, 1'b0);
        idle_cycles(3);
        n_cmp++;
        if (mon_a.size() != NPIX) begin n_bad++; $display("FAIL t4_count got %0d want %0d", mon_a.size(), NPIX); end
        for (int i = 0; i < mon_a.size() && i < exp_a.size(); i++) begin
            n_cmp++;
            if (mon_a[i].addr !== AW'(exp_a[i].addr) || mon_a[i].data !== exp_a[i].data || mon_a[i].layer !== 2'd1 ||
                mon_a[i].cyc != exp_a[i].cyc) begin
                n_bad++;
                if (shown++ < 20)
                    $display("FAIL t4_write[%0d] got addr=%0d data=%h layer=%0d cyc=%0d want addr=%0d data=%h layer=1 cyc=%0d",
                             i, mon_a[i].addr, mon_a[i].data, mon_a[i].layer, mon_a[i].cyc,
                             exp_a[i].addr, exp_a[i].data, exp_a[i].cyc);
            end
        end
        n_cmp++;
        if (done_a != 1 || err_a != 0) begin
            n_bad++;
            $display("FAIL t4_end got done=%0d err=%0d want 1 0", done_a, err_a);
        end
    endtask

    task automatic test_timeout();
        int last_b;
        clear_logs();
        send_hdr(0, 8'h00);
        send_pixels(0, 0, 10, 1'b0);
        last_b = exp_a[9].cyc;
        idle_cycles(80);
        n_cmp++;
        if (err_a != 0) begin n_bad++; $display("FAIL t5_early_err got err at cycle %0d (last byte %0d)", err_cyc_a, last_b); end
        idle_cycles(30);
        n_cmp++;
        if (err_a != 1 || err_cyc_a - last_b < TMO || err_cyc_a - last_b > TMO + 1) begin
            n_bad++;
            $display("FAIL t5_timeout got err_cycles=%0d idle_before_err=%0d want 1 and %0d..%0d",
                     err_a, err_cyc_a - last_b, TMO, TMO + 1);
        end
        n_cmp++;
        if (mon_a.size() != 10 || done_a != 0 || a_busy !== 1'b0 || late_a != 0) begin
            n_bad++;
            $display("FAIL t5_abort got writes=%0d done=%0d busy=%b late_busy=%0d want 10 0 0 0",
                     mon_a.size(), done_a, a_busy, late_a);
        end
        for (int i = 0; i < mon_a.size() && i < exp_a.size(); i++) begin
            n_cmp++;
            if (mon_a[i].addr !== AW'(exp_a[i].addr) || mon_a[i].data !== exp_a[i].data) begin
                n_bad++;
                $display("FAIL t5_write[%0d] got addr=%0d data=%h want addr=%0d data=%h",
                         i, mon_a[i].addr, mon_a[i].data, exp_a[i].addr, exp_a[i].data);
            end
        end
        for (int k = 0; k < 9; k++) send_byte(0, rnd_non_sync(), rand_gap());
        idle_cycles(3);
        n_cmp++;
        if (mon_a.size() != 10 || a_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL t5_resume got writes=%0d busy=%b want 10 0", mon_a.size(), a_busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_logs();
        send_hdr(0, 8'h02);
        send_pixels(0, 0, 100, 1'b0);
        send_byte(0, 8'h12, 0);
        send_byte(0, 8'h34, 0);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (a_wr_en !== 1'b0 || a_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL t6_reset_now got wr_en=%b busy=%b want 0 0", a_wr_en, a_busy);
        end
        repeat (3) @(posedge clk); #1;
        n_cmp++;
        if (a_wr_en !== 1'b0 || a_busy !== 1'b0 || mon_a.size() != 100) begin
            n_bad++;
            $display("FAIL t6_reset_hold got wr_en=%b busy=%b writes=%0d want 0 0 100", a_wr_en, a_busy, mon_a.size());
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        clear_logs();
        send_hdr(0, 8'h01);
        send_pixels(0, 0, NPIX, 1'b0);
        idle_cycles(3);
        n_cmp++;
        if (mon_a.size() != NPIX) begin n_bad++; $display("FAIL t6_count got %0d want %0d", mon_a.size(), NPIX); end
        for (int i = 0; i < mon_a.size() && i < exp_a.size(); i++) begin
            n_cmp++;
            if (mon_a[i].addr !== AW'(exp_a[i].addr) || mon_a[i].data !== exp_a[i].data || mon_a[i].layer !== 2'd1 ||
                mon_a[i].done !== (i == NPIX - 1)) begin
                n_bad++;
                if (shown++ < 20)
                    $display("FAIL t6_write[%0d] got addr=%0d data=%h layer=%0d want addr=%0d data=%h layer=1",
                             i, mon_a[i].addr, mon_a[i].data, mon_a[i].layer, exp_a[i].addr, exp_a[i].data);
            end
        end
        n_cmp++;
        if (done_a != 1 || err_a != 0 || a_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL t6_end got done=%0d err=%0d busy=%b want 1 0 0", done_a, err_a, a_busy);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_mirror();
        test_bad_layer();
        test_sync_hunt();
        test_timeout();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
